// File: rtl/rx_cmd_framer.sv
// Byte-stream command framer: assembles opcode/payload byte sequences into
// register-file and ALU commands, holding each until the controller accepts it.
module rx_cmd_framer #(
    parameter int data_width     = 8,
    parameter int address_width  = 4,
    parameter int alu_fun_width  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_rx_d_valid,
    input  logic [data_width-1:0]    i_p_data,
    input  logic                     i_cmd_ready,
    output logic                     o_cmd_valid,
    output logic [1:0]               o_cmd_type,
    output logic [address_width-1:0] o_address,
    output logic [data_width-1:0]    o_wr_data,
    output logic [data_width-1:0]    o_op_a,
    output logic [data_width-1:0]    o_op_b,
    output logic [alu_fun_width-1:0] o_alu_fun,
    output logic                     o_frame_err,
    output logic                     o_busy
);

    localparam int cnt_width = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [cnt_width-1:0] cnt_limit = cnt_width'(TIMEOUT_CYCLES - 1);

    localparam logic [data_width-1:0] op_wr  = data_width'(8'hAA);
    localparam logic [data_width-1:0] op_rd  = data_width'(8'hBB);
    localparam logic [data_width-1:0] op_alu = data_width'(8'hCC);
    localparam logic [data_width-1:0] op_fun = data_width'(8'hDD);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_A,
        GET_B,
        GET_FUN,
        HOLD
    } state_t;

    state_t               state_reg;
    logic [cnt_width-1:0] cnt_reg;

    logic   op_hit;
    logic   [1:0] op_type;
    state_t op_next;

    always_comb begin
        op_hit  = 1'b1;
        op_type = 2'b00;
        op_next = GET_ADDR;
        case (i_p_data)
            op_wr:   op_type = 2'b00;
            op_rd:   op_type = 2'b01;
            op_alu:  begin op_type = 2'b10; op_next = GET_A;   end
            op_fun:  begin op_type = 2'b11; op_next = GET_FUN; end
            default: op_hit  = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_type  <= '0;
            o_address   <= '0;
            o_wr_data   <= '0;
            o_op_a      <= '0;
            o_op_b      <= '0;
            o_alu_fun   <= '0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (i_rx_d_valid) begin
                        if (op_hit) begin
                            o_cmd_type <= op_type;
                            o_address  <= '0;
                            o_wr_data  <= '0;
                            o_op_a     <= '0;
                            o_op_b     <= '0;
                            o_alu_fun  <= '0;
                            state_reg  <= op_next;
                            o_busy     <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // An overrun byte is dropped; acceptance still completes normally.
                    if (i_rx_d_valid) begin
                        o_frame_err <= 1'b1;
                    end
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        state_reg   <= IDLE;
                        o_busy      <= 1'b0;
                    end
                end

                default: begin
                    if (i_rx_d_valid) begin
                        cnt_reg <= '0;
                        case (state_reg)
                            GET_ADDR: begin
                                o_address <= i_p_data[address_width-1:0];
                                if (o_cmd_type == 2'b00) begin
                                    state_reg <= GET_DATA;
                                end else begin
                                    state_reg   <= HOLD;
                                    o_cmd_valid <= 1'b1;
                                end
                            end
                            GET_DATA: begin
                                o_wr_data   <= i_p_data;
                                state_reg   <= HOLD;
                                o_cmd_valid <= 1'b1;
                            end
                            GET_A: begin
                                o_op_a    <= i_p_data;
                                state_reg <= GET_B;
                            end
                            GET_B: begin
                                o_op_b    <= i_p_data;
                                state_reg <= GET_FUN;
                            end
                            default: begin
                                o_alu_fun   <= i_p_data[alu_fun_width-1:0];
                                state_reg   <= HOLD;
                                o_cmd_valid <= 1'b1;
                            end
                        endcase
                    end else if (cnt_reg == cnt_limit) begin
                        o_frame_err <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= IDLE;
                        o_busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_cmd_framer.sv
// Bench for rx_cmd_framer: fixed command table, directed corner sequences and
// randomized frames checked against a frame-level model.
module tb_rx_cmd_framer;

    logic       i_clk;
    logic       i_arst_n;
    logic       i_rx_d_valid;
    logic [7:0] i_p_data;
    logic       i_cmd_ready;
    logic       o_cmd_valid;
    logic [1:0] o_cmd_type;
    logic [3:0] o_address;
    logic [7:0] o_wr_data;
    logic [7:0] o_op_a;
    logic [7:0] o_op_b;
    logic [3:0] o_alu_fun;
    logic       o_frame_err;
    logic       o_busy;

    rx_cmd_framer #(
        .data_width    (8),
        .address_width (4),
        .alu_fun_width (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_rx_d_valid(i_rx_d_valid),
        .i_p_data    (i_p_data),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_type  (o_cmd_type),
        .o_address   (o_address),
        .o_wr_data   (o_wr_data),
        .o_op_a      (o_op_a),
        .o_op_b      (o_op_b),
        .o_alu_fun   (o_alu_fun),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    always @(posedge i_clk) begin
        #1;
        if (o_frame_err === 1'b1) err_cnt++;
    end

    typedef struct {
        int          len;
        logic [31:0] bytes;
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  wr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [1:0] t, input logic [3:0] ad,
                             input logic [7:0] wd, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] f);
        check({tag, ".valid"}, 32'(o_cmd_valid), 32'd1);
        check({tag, ".type"},  32'(o_cmd_type),  32'(t));
        check({tag, ".addr"},  32'(o_address),   32'(ad));
        check({tag, ".wr"},    32'(o_wr_data),   32'(wd));
        check({tag, ".op_a"},  32'(o_op_a),      32'(a));
        check({tag, ".op_b"},  32'(o_op_b),      32'(b));
        check({tag, ".fun"},   32'(o_alu_fun),   32'(f));
    endtask

    // Called at a negedge; the byte is consumed at the next posedge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_d_valid = 1'b1;
        i_p_data     = b;
        @(negedge i_clk);
        i_rx_d_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic accept(input string tag);
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        i_cmd_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(o_cmd_valid), 32'd0);
        check({tag, ".busy_drop"},  32'(o_busy),      32'd0);
    endtask

    logic [7:0] ops [4];
    int         lens [4];

    initial begin
        ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
        lens[0] = 2; lens[1] = 1; lens[2] = 3; lens[3] = 1;

        vecs[0] = '{3, 32'hAA053C00, 2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0};
        vecs[1] = '{2, 32'hBB070000, 2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[2] = '{4, 32'hCC1234F1, 2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1};
        vecs[3] = '{2, 32'hDD020000, 2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2};
        vecs[4] = '{3, 32'hAAF90000, 2'b00, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[5] = '{2, 32'hBBFF0000, 2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[6] = '{4, 32'hCCFF008E, 2'b10, 4'h0, 8'h00, 8'hFF, 8'h00, 4'hE};
        vecs[7] = '{2, 32'hDD5A0000, 2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA};

        i_arst_n = 1'b1; i_rx_d_valid = 1'b0; i_p_data = 8'h00; i_cmd_ready = 1'b0;
        #2 i_arst_n = 1'b0;
        idle(2);
        check("rst.valid", 32'(o_cmd_valid), 32'd0);
        check("rst.busy",  32'(o_busy),      32'd0);
        check("rst.err",   32'(o_frame_err), 32'd0);
        check("rst.type",  32'(o_cmd_type),  32'd0);
        i_arst_n = 1'b1;
        idle(1);

        // Command table.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].len; i++) send_byte(vecs[v].bytes[31-8*i -: 8]);
            check_cmd($sformatf("vec%0d", v), vecs[v].typ, vecs[v].addr, vecs[v].wr,
                      vecs[v].a, vecs[v].b, vecs[v].fun);
            accept($sformatf("vec%0d", v));
            $display("vec %0d bytes=%h type=%0d", v, vecs[v].bytes, vecs[v].typ);
        end

        // Ready already high: valid lasts exactly one cycle.
        i_cmd_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check_cmd("rdy_hi", 2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        idle(1);
        check("rdy_hi.one_cycle", 32'(o_cmd_valid), 32'd0);
        i_cmd_ready = 1'b0;
        $display("seq ready-high write done");

        // Long hold.
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'hF1);
        for (int i = 0; i < 10; i++) begin
            check_cmd($sformatf("hold%0d", i), 2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1);
            idle(1);
        end
        accept("hold");
        $display("seq long hold done");

        // Garbage byte in IDLE.
        send_byte(8'h55);
        check("bad.err",  32'(o_frame_err), 32'd1);
        check("bad.busy", 32'(o_busy),      32'd0);
        idle(1);
        check("bad.err_pulse", 32'(o_frame_err), 32'd0);
        send_byte(8'hBB); send_byte(8'h07);
        check_cmd("after_bad", 2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
        accept("after_bad");
        $display("seq bad opcode done");

        // Timeout at the 16th idle cycle.
        send_byte(8'hAA); send_byte(8'h03);
        idle(15);
        check("to.no_err_yet", 32'(o_frame_err), 32'd0);
        check("to.busy_yet",   32'(o_busy),      32'd1);
        idle(1);
        check("to.err",  32'(o_frame_err), 32'd1);
        check("to.busy", 32'(o_busy),      32'd0);
        check("to.valid", 32'(o_cmd_valid), 32'd0);
        idle(1);
        check("to.err_pulse", 32'(o_frame_err), 32'd0);
        send_byte(8'hDD); send_byte(8'h02);
        check_cmd("after_to", 2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
        accept("after_to");
        $display("seq timeout done");

        // Byte landing on the threshold cycle is consumed.
        begin
            int e0;
            e0 = err_cnt;
            send_byte(8'hAA); idle(15); send_byte(8'h05); idle(15); send_byte(8'h3C);
            check_cmd("edge", 2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
            accept("edge");
            idle(1);
            check("edge.no_err", 32'(err_cnt - e0), 32'd0);
        end
        $display("seq threshold byte done");

        // Overrun in HOLD, alone and together with ready.
        send_byte(8'hBB); send_byte(8'h07);
        send_byte(8'h99);
        check("ovr.err", 32'(o_frame_err), 32'd1);
        check_cmd("ovr", 2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
        i_cmd_ready = 1'b1;
        send_byte(8'hAA);
        i_cmd_ready = 1'b0;
        check("ovr2.err",   32'(o_frame_err), 32'd1);
        check("ovr2.valid", 32'(o_cmd_valid), 32'd0);
        check("ovr2.busy",  32'(o_busy),      32'd0);
        check("ovr2.addr",  32'(o_address),   32'd7);
        check("ovr2.type",  32'(o_cmd_type),  32'd1);
        $display("seq overrun done");

        // Asynchronous reset mid-frame and in HOLD.
        send_byte(8'hCC); send_byte(8'h12);
        #1 i_arst_n = 1'b0;
        #1;
        check("arst.busy", 32'(o_busy),     32'd0);
        check("arst.op_a", 32'(o_op_a),     32'd0);
        check("arst.type", 32'(o_cmd_type), 32'd0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        check_cmd("after_arst", 2'b00, 4'h1, 8'hFF, 8'h00, 8'h00, 4'h0);
        #1 i_arst_n = 1'b0;
        #1;
        check("arst_hold.valid", 32'(o_cmd_valid), 32'd0);
        check("arst_hold.addr",  32'(o_address),   32'd0);
        check("arst_hold.wr",    32'(o_wr_data),   32'd0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        send_byte(8'hDD); send_byte(8'h04);
        check_cmd("after_arst2", 2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4);
        accept("after_arst2");
        $display("seq async reset done");

        // Randomized frames against a frame-level model.
        for (int it = 0; it < 60; it++) begin
            int kind, e0, exp_err, k, oi;
            logic [7:0] pay [3];
            logic [7:0] b;
            e0 = err_cnt;
            exp_err = 0;
            kind = $urandom_range(0, 5);
            oi = $urandom_range(0, 3);
            for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
            if (kind == 0) begin
                b = 8'($urandom);
                while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
                i_cmd_ready = 1'($urandom);
                send_byte(b);
                i_cmd_ready = 1'b0;
                check("rnd.bad_err",  32'(o_frame_err), 32'd1);
                check("rnd.bad_busy", 32'(o_busy),      32'd0);
                exp_err = 1;
            end else if (kind == 1) begin
                k = $urandom_range(0, lens[oi] - 1);
                send_byte(ops[oi]);
                for (int i = 0; i < k; i++) begin
                    idle($urandom_range(0, 15));
                    send_byte(pay[i]);
                end
                idle(16 + $urandom_range(0, 4));
                check("rnd.to_busy",  32'(o_busy),      32'd0);
                check("rnd.to_valid", 32'(o_cmd_valid), 32'd0);
                exp_err = 1;
            end else begin
                logic [1:0] t; logic [3:0] ad, f; logic [7:0] wd, a, bb;
                send_byte(ops[oi]);
                for (int i = 0; i < lens[oi]; i++) begin
                    idle($urandom_range(0, 15));
                    send_byte(pay[i]);
                end
                t  = 2'(oi);
                ad = (oi < 2) ? pay[0][3:0] : 4'h0;
                wd = (oi == 0) ? pay[1] : 8'h00;
                a  = (oi == 2) ? pay[0] : 8'h00;
                bb = (oi == 2) ? pay[1] : 8'h00;
                f  = (oi == 2) ? pay[2][3:0] : (oi == 3) ? pay[0][3:0] : 4'h0;
                check_cmd("rnd.cmd", t, ad, wd, a, bb, f);
                repeat ($urandom_range(0, 3)) begin
                    idle(1);
                    check("rnd.hold_valid", 32'(o_cmd_valid), 32'd1);
                end
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(8'($urandom));
                    check("rnd.ovr_err", 32'(o_frame_err), 32'd1);
                    check_cmd("rnd.ovr", t, ad, wd, a, bb, f);
                    exp_err = 1;
                end
                accept("rnd");
            end
            idle($urandom_range(1, 20));
            check("rnd.err_count", 32'(err_cnt - e0), 32'(exp_err));
            $display("rnd %0d kind=%0d op=%h errs=%0d", it, kind, ops[oi], err_cnt - e0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
